mem_arb: RTL

Two-requester memory bus arbiter for the MINA CPU: shares one external memory bus between instruction fetch (I port) and the MEM stage's load/store path (D port). Sequences each bus transaction through a small FSM, gives data accesses priority with a starvation guard for fetch, and returns a one-cycle completion pulse with read data to the winning requester. Sits between the IF/MEM stages and the memory/peripheral interconnect.

---
 rtl/mem_arb.sv | 183 ++++++++++++++++++
 1 files changed

// File: rtl/mem_arb.sv
// rtl/mem_arb.sv - two-requester memory bus arbiter (fetch vs load/store)
//
// Shares one external memory bus between instruction fetch (i_*) and the
// MEM-stage load/store path (d_*). Data accesses win ties unless D has been
// granted STREAK_MAX times in a row while fetch was waiting.
//
// Ports:
//   clk, rst_n               clock, asynchronous active-low reset
//   i_req/i_addr             fetch request, held until i_done
//   i_done/i_rdata/i_err     fetch completion pulse, read data, abort flag
//   d_req/d_we/d_addr/
//   d_wdata/d_be             load/store request, held until d_done
//   d_done/d_rdata/d_err     data completion pulse, load data, abort flag
//   bus_req/bus_we/bus_addr/
//   bus_wdata/bus_be         registered bus transaction fields
//   bus_ack/bus_rdata        bus completion and read data
//
// Optional feature macro: MINA_ARB_TIMEOUT_EN (bus wait timeout after
// TIMEOUT_CYC busy cycles, reported through i_err/d_err).

module mem_arb #(
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter int STREAK_MAX  = 4,
    parameter int TIMEOUT_CYC = 255
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                i_req,
    input  logic [ADDR_W-1:0]   i_addr,
    output logic                i_done,
    output logic [DATA_W-1:0]   i_rdata,
    output logic                i_err,
    input  logic                d_req,
    input  logic                d_we,
    input  logic [ADDR_W-1:0]   d_addr,
    input  logic [DATA_W-1:0]   d_wdata,
    input  logic [DATA_W/8-1:0] d_be,
    output logic                d_done,
    output logic [DATA_W-1:0]   d_rdata,
    output logic                d_err,
    output logic                bus_req,
    output logic                bus_we,
    output logic [ADDR_W-1:0]   bus_addr,
    output logic [DATA_W-1:0]   bus_wdata,
    output logic [DATA_W/8-1:0] bus_be,
    input  logic                bus_ack,
    input  logic [DATA_W-1:0]   bus_rdata
);

    localparam int BE_W = DATA_W / 8;
    localparam int SW   = $clog2(STREAK_MAX + 1);
    localparam logic [SW-1:0] STREAK_SAT = SW'(STREAK_MAX);

    typedef enum logic [1:0] {IDLE, BUSY_I, BUSY_D, DONE} state_t;

    state_t        state, state_nx;
    logic [SW-1:0] streak;
    logic          grant_i, grant_d, timeout;

`ifdef MINA_ARB_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYC + 1);
    logic [TW-1:0] tcnt;

    // Counter value reaches TIMEOUT_CYC-1 on the TIMEOUT_CYC-th busy edge;
    // a simultaneous ack takes precedence.
    always_comb begin
        timeout = 1'b0;
        if ((state == BUSY_I || state == BUSY_D) && !bus_ack)
            timeout = (tcnt == TW'(TIMEOUT_CYC - 1));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tcnt  <= '0;
            i_err <= 1'b0;
            d_err <= 1'b0;
        end else begin
            if (state == IDLE)
                tcnt <= '0;
            else if (state == BUSY_I || state == BUSY_D)
                tcnt <= tcnt + 1'b1;
            i_err <= (state == BUSY_I) && timeout;
            d_err <= (state == BUSY_D) && timeout;
        end
    end
`else
    assign timeout = 1'b0;
    assign i_err   = 1'b0;
    assign d_err   = 1'b0;
    wire unused_timeout = (TIMEOUT_CYC != 0);
`endif

    // Grant decision only happens in IDLE; DONE deliberately skips it because
    // the finished requester still shows its old request that cycle.
    always_comb begin
        grant_d = 1'b0;
        grant_i = 1'b0;
        if (state == IDLE) begin
            grant_d = d_req && (!i_req || streak != STREAK_SAT);
            grant_i = i_req && !grant_d;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE: begin
                if (grant_d)      state_nx = BUSY_D;
                else if (grant_i) state_nx = BUSY_I;
            end
            BUSY_I, BUSY_D: begin
                if (bus_ack || timeout) state_nx = DONE;
            end
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            streak    <= '0;
            bus_req   <= 1'b0;
            bus_we    <= 1'b0;
            bus_addr  <= '0;
            bus_wdata <= '0;
            bus_be    <= '0;
            i_done    <= 1'b0;
            i_rdata   <= '0;
            d_done    <= 1'b0;
            d_rdata   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (grant_d) begin
                        bus_req   <= 1'b1;
                        bus_we    <= d_we;
                        bus_addr  <= d_addr;
                        bus_wdata <= d_wdata;
                        bus_be    <= d_be;
                        // Streak only grows while fetch is actually waiting.
                        if (!i_req)
                            streak <= '0;
                        else if (streak != STREAK_SAT)
                            streak <= streak + 1'b1;
                    end else if (grant_i) begin
                        bus_req   <= 1'b1;
                        bus_we    <= 1'b0;
                        bus_addr  <= i_addr;
                        bus_wdata <= '0;
                        bus_be    <= {BE_W{1'b1}};
                        streak    <= '0;
                    end
                end
                BUSY_I: begin
                    if (bus_ack || timeout) begin
                        bus_req <= 1'b0;
                        i_done  <= 1'b1;
                        i_rdata <= bus_ack ? bus_rdata : '0;
                    end
                end
                BUSY_D: begin
                    if (bus_ack || timeout) begin
                        bus_req <= 1'b0;
                        d_done  <= 1'b1;
                        d_rdata <= (bus_ack && !bus_we) ? bus_rdata : '0;
                    end
                end
                DONE: begin
                    i_done <= 1'b0;
                    d_done <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule
